ddr2_local_port_arbiter: RTL
============================

# ddr2_local_port_arbiter

Multi-port front end for the DDR2 controller's local (Avalon-style) interface. It merges NUM_PORTS independent requesters onto the single `local_*` port of the controller/PHY top. Arbitration is round-robin, and write bursts are held atomic. A tag FIFO routes returning read beats back to the port that issued the read. It sits between the user masters and the controller/PHY top, in the `phy_clk` domain.

## Interface
Parameters:
- NUM_PORTS, 4, number of requesting ports (2..8)
- ADDR_W, 24, local address width
- DATA_W, 128, local data width
- BE_W, 16, byte-enable width (DATA_W/8)
- SIZE_W, 3, burst-size width; a burst is 1..2^SIZE_W-1 beats
- TAG_DEPTH, 16, maximum number of outstanding read commands (power of two)

Ports (per-port buses are flattened, port p occupies slice p):
- clk  in  1  phy_clk of the controller; the only clock
- reset  in  1  asynchronous, active-high
- port_read_req / port_write_req / port_burstbegin  in  NUM_PORTS  per-port command strobes
- port_address  in  NUM_PORTS*ADDR_W  command address
- port_size  in  NUM_PORTS*SIZE_W  burst length
- port_be  in  NUM_PORTS*BE_W  byte enables
- port_wdata  in  NUM_PORTS*DATA_W  write data
- port_ready  out  NUM_PORTS  command/beat accepted this cycle when high with a req
- port_rdata  out  DATA_W  registered read data, broadcast to all ports
- port_rdata_valid  out  NUM_PORTS  one-hot read-beat qualifier
- local_read_req, local_write_req, local_burstbegin, local_address, local_size, local_be, local_wdata  out  —  to the controller
- local_ready  in  1  controller accept
- local_rdata  in  DATA_W; local_rdata_valid  in  1  controller read return
- err_orphan_rdata  out  1  sticky: a read beat arrived with no outstanding tag

## Operation
- States: IDLE, WR_BURST.
- IDLE: grant the first requesting port at or after rr_ptr (wrapping). The grant is combinational, and the downstream command outputs are a mux of the granted port.
- A read request is eligible only when the tag FIFO is not full. A port whose read is blocked is skipped; it is not stalled.
- Accept = local_ready & granted request.
- On an accepted read: push {port_id, size} to the tag FIFO; rr_ptr ← grant+1.
- On an accepted write with size>1: load beat_cnt = size−1 and lock the grant to that port; go to WR_BURST.
- Size 1 write: rr_ptr ← grant+1; stay in IDLE.
- WR_BURST: only the locked port is muxed. Each accepted beat decrements beat_cnt. When beat_cnt reaches 0 on accept: go to IDLE and set rr_ptr ← lock+1. Other ports' requests are ignored.
- port_ready[p] = local_ready & (p is granted) & eligibility. All other bits are 0.
- Read return: each local_rdata_valid beat is steered to the head tag's port and decrements head_cnt. On the last beat the tag is popped.
- Push and pop may occur in the same cycle; occupancy is unchanged.
- local_rdata_valid with an empty FIFO: the beat is dropped and err_orphan_rdata is set. It is cleared only by reset.
- local_burstbegin is asserted on the first beat of each granted command.

## Timing
- Command path: zero added latency (combinational through the mux).
- Read data path: exactly 1 cycle (port_rdata and port_rdata_valid are registered).
- Reset values:
  - state=IDLE, rr_ptr=0, beat_cnt=0, FIFO empty, head_cnt=0
  - port_rdata=0, port_rdata_valid=0, err_orphan_rdata=0
  - port_ready=0 and all local_* request strobes=0 while reset is high
- Reset mid-burst abandons the burst and flushes all tags. Downstream recovery is the controller's responsibility.
- A full FIFO that pops in the same cycle does not accept a read that cycle; the full flag is registered.

## Configuration
- DDR2_ARB_PRIORITY_EN defined:
  - adds input `port_priority` [NUM_PORTS].
  - in IDLE, if any eligible requester has priority set, round-robin is restricted to those requesters.
  - WR_BURST lock still wins.
- Undefined: the port does not exist; pure round-robin.

## Structure
- Package ddr2_arb_pkg:
  - state enum {IDLE, WR_BURST}
  - PORT_ID_W = $clog2(NUM_PORTS) helper
  - tag struct {port_id, size}
- Sub-module ddr2_arb_tag_fifo:
  - synchronous FIFO of tags, depth TAG_DEPTH
  - outputs full, empty, and head
  - the head counter lives in the parent

## Test plan
- Ports 0..3 each issue one read of size 1, back-to-back, local_ready=1 → grants 0,1,2,3; returned beats go out on port_rdata_valid 0001, 0010, 0100, 1000, each 1 cycle after local_rdata_valid.
- Port 1 writes size 4 while port 2 requests → four consecutive port_ready[1] pulses with port 2 locked out; port 2 is granted in the next cycle; rr_ptr=3.
- local_ready held low for 5 cycles mid-burst → no beats accepted and beat_cnt holds; the burst completes once ready returns.
- 16 outstanding reads, then a 17th request → port_ready stays 0 for that read until a pop; a write from another port is still granted meanwhile.
- local_rdata_valid with no outstanding reads → no port_rdata_valid; err_orphan_rdata=1 and stays set.
- Reset asserted in WR_BURST after 2 of 4 beats → outputs return to reset values asynchronously; after release, a fresh read from port 0 is granted.

Source files
------------

// File: rtl/ddr2_arb_pkg.sv
// ddr2_arb_pkg: shared types for the DDR2 local-port arbiter.
package ddr2_arb_pkg;
    typedef enum logic {IDLE, WR_BURST} state_t;
    localparam int MAX_PORT_ID_W = 3;
    localparam int MAX_SIZE_W = 8;
    typedef struct packed {
        logic [MAX_PORT_ID_W-1:0] port_id;
        logic [MAX_SIZE_W-1:0]    size;
    } tag_t;
    function automatic int port_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ddr2_arb_tag_fifo.sv
// ddr2_arb_tag_fifo: synchronous FIFO of outstanding read tags; full/empty come from the registered count.
module ddr2_arb_tag_fifo
    import ddr2_arb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  tag_t din,
    output tag_t head,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    tag_t mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic do_push, do_pop;
    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign head = mem[rp];
    assign do_push = push & ~full;
    assign do_pop = pop & ~empty;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) if (do_push) mem[wp] <= din;
endmodule

// File: rtl/ddr2_local_port_arbiter.sv
// ddr2_local_port_arbiter: round-robin multi-port front end for the DDR2 local interface with atomic write bursts.
// Optional DDR2_ARB_PRIORITY_EN adds port_priority, restricting round-robin to prioritised eligible ports.
module ddr2_local_port_arbiter
    import ddr2_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W = 24,
    parameter int DATA_W = 128,
    parameter int BE_W = 16,
    parameter int SIZE_W = 3,
    parameter int TAG_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          port_read_req,
    input  logic [NUM_PORTS-1:0]          port_write_req,
    input  logic [NUM_PORTS-1:0]          port_burstbegin,
`ifdef DDR2_ARB_PRIORITY_EN
    input  logic [NUM_PORTS-1:0]          port_priority,
`endif
    input  logic [NUM_PORTS*ADDR_W-1:0]   port_address,
    input  logic [NUM_PORTS*SIZE_W-1:0]   port_size,
    input  logic [NUM_PORTS*BE_W-1:0]     port_be,
    input  logic [NUM_PORTS*DATA_W-1:0]   port_wdata,
    output logic [NUM_PORTS-1:0]          port_ready,
    output logic [DATA_W-1:0]             port_rdata,
    output logic [NUM_PORTS-1:0]          port_rdata_valid,
    output logic                          local_read_req,
    output logic                          local_write_req,
    output logic                          local_burstbegin,
    output logic [ADDR_W-1:0]             local_address,
    output logic [SIZE_W-1:0]             local_size,
    output logic [BE_W-1:0]               local_be,
    output logic [DATA_W-1:0]             local_wdata,
    input  logic                          local_ready,
    input  logic [DATA_W-1:0]             local_rdata,
    input  logic                          local_rdata_valid,
    output logic                          err_orphan_rdata
);
    localparam int PW = port_id_w(NUM_PORTS);
    state_t state;
    logic [PW-1:0] rr_ptr, lock, g;
    logic [SIZE_W-1:0] beat_cnt, head_cnt, remain;
    logic [NUM_PORTS-1:0] elig, cand;
    logic gnt_valid, gnt_wr, acc, full, empty, push, pop, unused_bits;
    tag_t head;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] x);
        return (int'(x) == NUM_PORTS - 1) ? '0 : x + 1'b1;
    endfunction
    assign elig = port_write_req | (port_read_req & {NUM_PORTS{~full}});
`ifdef DDR2_ARB_PRIORITY_EN
    assign cand = |(elig & port_priority) ? elig & port_priority : elig;
`else
    assign cand = elig;
`endif
    // Burst lock overrides the round-robin search so beats stay contiguous.
    always_comb begin
        int k;
        g = rr_ptr;
        gnt_valid = 1'b0;
        k = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            k = (int'(rr_ptr) + i) % NUM_PORTS;
            if (!gnt_valid && cand[k]) begin
                g = PW'(k);
                gnt_valid = 1'b1;
            end
        end
        if (state == WR_BURST) begin
            g = lock;
            gnt_valid = port_write_req[lock];
        end
    end
    assign gnt_wr = port_write_req[g];
    assign acc = local_ready & gnt_valid & ~reset;
    assign port_ready = acc ? NUM_PORTS'(1) << g : '0;
    assign local_write_req = ~reset & gnt_valid & gnt_wr;
    assign local_read_req = ~reset & gnt_valid & ~gnt_wr;
    assign local_burstbegin = ~reset & gnt_valid & (state == IDLE);
    assign local_address = port_address[g*ADDR_W +: ADDR_W];
    assign local_size = port_size[g*SIZE_W +: SIZE_W];
    assign local_be = port_be[g*BE_W +: BE_W];
    assign local_wdata = port_wdata[g*DATA_W +: DATA_W];
    assign push = acc & ~gnt_wr;
    assign remain = (head_cnt == '0) ? head.size[SIZE_W-1:0] : head_cnt;
    assign pop = local_rdata_valid & ~empty & (remain <= SIZE_W'(1));
    assign unused_bits = ^{port_burstbegin, head};
    ddr2_arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tags (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .din('{port_id: MAX_PORT_ID_W'(g), size: MAX_SIZE_W'(local_size)}),
        .head(head),
        .full(full),
        .empty(empty)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rr_ptr <= '0;
            lock <= '0;
            beat_cnt <= '0;
            head_cnt <= '0;
            port_rdata <= '0;
            port_rdata_valid <= '0;
            err_orphan_rdata <= 1'b0;
        end else begin
            if (acc && state == IDLE) begin
                if (gnt_wr && local_size > SIZE_W'(1)) begin
                    beat_cnt <= local_size - 1'b1;
                    lock <= g;
                    state <= WR_BURST;
                end else rr_ptr <= nxt(g);
            end else if (acc) begin
                beat_cnt <= beat_cnt - 1'b1;
                if (beat_cnt <= SIZE_W'(1)) begin
                    state <= IDLE;
                    rr_ptr <= nxt(lock);
                end
            end
            port_rdata_valid <= (local_rdata_valid && !empty) ? NUM_PORTS'(1) << head.port_id[PW-1:0] : '0;
            if (local_rdata_valid && !empty) begin
                port_rdata <= local_rdata;
                head_cnt <= pop ? '0 : remain - 1'b1;
            end
            if (local_rdata_valid && empty) err_orphan_rdata <= 1'b1;
        end
    end
endmodule
